alb: RTL and testbench



---
 rtl/alb_if.sv | 24 ++
 rtl/alb.sv | 80 ++++++++
 tb/tb_alb.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alb_if.sv
// Operand/opcode inputs and registered result/flag outputs of the ALB.
interface alb_if;
  logic [7:0] R_in;
  logic [7:0] S_in;
  logic       CI_in;
  logic [1:0] ALB_MI;
  logic [7:0] F;
  logic       CO;
  logic       ZO;
  logic       NO;
  logic       VO;

  // Stimulus side: drives operands and opcode, observes results.
  modport master (
    output R_in, S_in, CI_in, ALB_MI,
    input  F, CO, ZO, NO, VO
  );

  // ALB side: consumes operands and opcode, produces results.
  modport slave (
    input  R_in, S_in, CI_in, ALB_MI,
    output F, CO, ZO, NO, VO
  );
endinterface

// File: rtl/alb.sv
// 8-bit arithmetic/logic block: ADD/SUB with carry, AND, OR; one registered stage.
module alb (
  input  logic  clk,
  input  logic  resetb,
  alb_if.slave  bus
);

  localparam int unsigned W = 8;

  localparam logic [1:0] OP_SUB = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic [W-1:0] f_d,  f_q;
  logic         co_d, co_q;
  logic         zo_d, zo_q;
  logic         no_d, no_q;
  logic         vo_d, vo_q;

  logic [W-1:0] s_opnd;
  logic [W:0]   sum;

  // Shared adder: SUB reuses it with the S operand inverted (CI=1 means no borrow-in).
  always_comb begin
    s_opnd = (bus.ALB_MI == OP_SUB) ? ~bus.S_in : bus.S_in;
    sum    = (W+1)'(bus.R_in) + (W+1)'(s_opnd) + (W+1)'(bus.CI_in);
  end

  // Next result and flags from the current inputs.
  always_comb begin
    f_d  = '0;
    co_d = 1'b0;
    vo_d = 1'b0;
    unique case (bus.ALB_MI)
      OP_ADD: begin
        f_d  = sum[W-1:0];
        co_d = sum[W];
        vo_d = (bus.R_in[W-1] == bus.S_in[W-1]) & (sum[W-1] != bus.R_in[W-1]);
      end
      OP_SUB: begin
        f_d  = sum[W-1:0];
        co_d = sum[W];
        vo_d = (bus.R_in[W-1] != bus.S_in[W-1]) & (sum[W-1] != bus.R_in[W-1]);
      end
      OP_AND: f_d = bus.R_in & bus.S_in;
      OP_OR:  f_d = bus.R_in | bus.S_in;
      default: f_d = '0;
    endcase
    zo_d = (f_d == '0);
    no_d = f_d[W-1];
  end

  // Output registers; reset clears them immediately and holds them at zero.
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      f_q  <= '0;
      co_q <= 1'b0;
      zo_q <= 1'b0;
      no_q <= 1'b0;
      vo_q <= 1'b0;
    end else begin
      f_q  <= f_d;
      co_q <= co_d;
      zo_q <= zo_d;
      no_q <= no_d;
      vo_q <= vo_d;
    end
  end

  // Drive the bus outputs from the registers.
  always_comb begin
    bus.F  = f_q;
    bus.CO = co_q;
    bus.ZO = zo_q;
    bus.NO = no_q;
    bus.VO = vo_q;
  end

endmodule

// File: tb/tb_alb.sv
// Scoreboard bench for alb: expected {F,CO,ZO,NO,VO} queued at drive time, popped after the edge.
module tb_alb;

  localparam logic [1:0] SUB = 2'b00;
  localparam logic [1:0] AND = 2'b01;
  localparam logic [1:0] ADD = 2'b10;
  localparam logic [1:0] OR  = 2'b11;

  logic clk;
  logic resetb;
  int   n_checks;
  int   n_pass;
  logic [11:0] exp_q[$];

  alb_if bus ();

  alb dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: integer arithmetic for carry, signed range test for overflow.
  function automatic logic [11:0] model(input logic [7:0] r, input logic [7:0] s,
                                        input logic ci, input logic [1:0] op);
    int res;
    int sres;
    int sr;
    int ss;
    logic [7:0] f;
    logic co;
    logic vo;
    sr = int'($signed(r));
    ss = int'($signed(s));
    f  = 8'h00;
    co = 1'b0;
    vo = 1'b0;
    case (op)
      ADD: begin
        res  = int'(r) + int'(s) + int'(ci);
        sres = sr + ss + int'(ci);
        f    = res[7:0];
        co   = (res > 255);
        vo   = (sres > 127) || (sres < -128);
      end
      SUB: begin
        res  = int'(r) - int'(s) - 1 + int'(ci);
        sres = sr - ss - 1 + int'(ci);
        f    = res[7:0];
        co   = (res >= 0);
        vo   = (sres > 127) || (sres < -128);
      end
      AND: f = r & s;
      default: f = r | s;
    endcase
    return {f, co, (f == 8'h00), f[7], vo};
  endfunction

  function automatic logic [11:0] observed();
    return {bus.F, bus.CO, bus.ZO, bus.NO, bus.VO};
  endfunction

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got F=%02h C=%b Z=%b N=%b V=%b, expected F=%02h C=%b Z=%b N=%b V=%b",
                  tag, got[11:4], got[3], got[2], got[1], got[0],
                  exp[11:4], exp[3], exp[2], exp[1], exp[0]);
  endtask

  task automatic drive(input logic [7:0] r, input logic [7:0] s, input logic ci, input logic [1:0] op);
    bus.R_in   = r;
    bus.S_in   = s;
    bus.CI_in  = ci;
    bus.ALB_MI = op;
  endtask

  // One operation per cycle: drive, queue expected, compare #1 after the capturing edge.
  task automatic run_op(input string tag, input logic [7:0] r, input logic [7:0] s,
                        input logic ci, input logic [1:0] op);
    logic [11:0] e;
    drive(r, s, ci, op);
    exp_q.push_back(model(r, s, ci, op));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, observed(), e);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    resetb   = 1'b1;
    drive(8'h7F, 8'h01, 1'b0, ADD);
    #1;
    check_eq("reset_state", observed(), 12'h000);
    @(posedge clk);
    #1;
    check_eq("reset_hold_edge", observed(), 12'h000);
    #2 resetb = 1'b0;

    // Directed cases, with literal expectations cross-checking the model.
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, ADD);
    check_eq("add_7f_01_lit", observed(), {8'h80, 4'b0011});
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, ADD);
    check_eq("add_ff_01_lit", observed(), {8'h00, 4'b1100});
    run_op("add_ff_00_c", 8'hFF, 8'h00, 1'b1, ADD);
    run_op("sub_05_03_c1", 8'h05, 8'h03, 1'b1, SUB);
    check_eq("sub_05_03_c1_lit", observed(), {8'h02, 4'b1000});
    run_op("sub_05_03_c0", 8'h05, 8'h03, 1'b0, SUB);
    check_eq("sub_05_03_c0_lit", observed(), {8'h01, 4'b1000});
    run_op("sub_00_01", 8'h00, 8'h01, 1'b1, SUB);
    check_eq("sub_00_01_lit", observed(), {8'hFF, 4'b0010});
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, SUB);
    check_eq("sub_80_01_lit", observed(), {8'h7F, 4'b1001});
    run_op("and_f0_3c", 8'hF0, 8'h3C, 1'b1, AND);
    check_eq("and_f0_3c_lit", observed(), {8'h30, 4'b0000});
    run_op("and_0f_f0", 8'h0F, 8'hF0, 1'b0, AND);
    run_op("or_f0_3c", 8'hF0, 8'h3C, 1'b1, OR);
    check_eq("or_f0_3c_lit", observed(), {8'hFC, 4'b0010});

    // Asynchronous reset mid-cycle while F is nonzero.
    #3 resetb = 1'b1;
    drive(8'h12, 8'h34, 1'b0, ADD);
    #1;
    check_eq("rst_async", observed(), 12'h000);
    @(posedge clk);
    #1;
    check_eq("rst_hold", observed(), 12'h000);
    #2 resetb = 1'b0;
    exp_q.push_back(model(8'h12, 8'h34, 1'b0, ADD));
    @(posedge clk);
    #1;
    check_eq("rst_release", observed(), exp_q.pop_front());

    // Random sweep, new opcode and operands every cycle.
    for (int i = 0; i < 1000; i++) begin
      run_op("random", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
